// File: rtl/audio_pkg.sv
// Shared constants and state encodings for the audio frame buffer.
// Mix modes select how stereo strobes reduce to the mono stream.
package audio_pkg;

    localparam int MIX_LEFT  = 0;
    localparam int MIX_RIGHT = 1;
    localparam int MIX_AVG   = 2;

    typedef enum logic {
        FILL,
        STALL
    } wr_state_e;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } rd_state_e;

    typedef enum logic {
        FREE,
        FULL
    } bank_state_e;

endpackage

// File: rtl/audio_frame_ram.sv
// Ping-pong sample storage: one write port, one registered read port.
// The read register only advances on rd_en so a stalled beat holds its value.
module audio_frame_ram #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [SAMPLE_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data
);

    logic [SAMPLE_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [SAMPLE_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// Reduces stereo PCM strobes to mono, packs them into ping-pong frames and
// streams each completed frame over valid/ready with a last-beat marker.
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 256,
    parameter int MIX_MODE     = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    channel_id,
    output logic [SAMPLE_WIDTH-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_last,
    input  logic                    ovf_clr,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic                    have_left_q, have_left_d;
    logic                    mono_valid_q, mono_valid_d;
    logic [SAMPLE_WIDTH-1:0] mono_data_q, mono_data_d;
    logic signed [SAMPLE_WIDTH:0] avg_sum;

    wr_state_e        wr_state_q, wr_state_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] rd_idx_nxt;
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    bank_state_e      bank_freed [2];

    logic             wr_en, rd_en, rd_fire, rd_done, drop;
    logic [IDX_W:0]   rd_addr;
    logic [SAMPLE_WIDTH-1:0] ram_rd_data;

    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;

    // Sum at one extra bit so the average cannot overflow; >>> floors.
    always_comb begin
        avg_sum      = $signed({left_q[SAMPLE_WIDTH-1], left_q})
                     + $signed({sample_in[SAMPLE_WIDTH-1], sample_in});
        left_d       = left_q;
        have_left_d  = have_left_q;
        mono_valid_d = 1'b0;
        mono_data_d  = mono_data_q;
        if (sample_valid) begin
            if (MIX_MODE == MIX_LEFT) begin
                if (!channel_id) begin
                    mono_valid_d = 1'b1;
                    mono_data_d  = sample_in;
                end
            end else if (MIX_MODE == MIX_RIGHT) begin
                if (channel_id) begin
                    mono_valid_d = 1'b1;
                    mono_data_d  = sample_in;
                end
            end else begin
                if (!channel_id) begin
                    left_d      = sample_in;
                    have_left_d = 1'b1;
                end else if (have_left_q) begin
                    mono_valid_d = 1'b1;
                    mono_data_d  = SAMPLE_WIDTH'(avg_sum >>> 1);
                    have_left_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_fire    = (rd_state_q == STREAM) && frame_ready;
        rd_done    = rd_fire && (rd_idx_q == LAST_IDX);
        bank_freed = bank_q;
        if (rd_done) begin
            bank_freed[rd_bank_q] = FREE;
        end

        // A bank released this cycle is already usable by the writer.
        bank_d     = bank_freed;
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        wr_en      = mono_valid_q && (wr_state_q == FILL);
        drop       = mono_valid_q && (wr_state_q == STALL);
        case (wr_state_q)
            FILL: begin
                if (wr_en) begin
                    if (wr_idx_q == LAST_IDX) begin
                        bank_d[wr_bank_q] = FULL;
                        wr_idx_d          = '0;
                        if (bank_freed[~wr_bank_q] == FREE) begin
                            wr_bank_d = ~wr_bank_q;
                        end else begin
                            wr_state_d = STALL;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            STALL: begin
                if (bank_freed[~wr_bank_q] == FREE) begin
                    wr_state_d = FILL;
                    wr_bank_d  = ~wr_bank_q;
                    wr_idx_d   = '0;
                end
            end
            default: wr_state_d = FILL;
        endcase

        // The RAM register only loads when the presented beat moves on.
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_idx_d   = rd_idx_q;
        rd_idx_nxt = rd_idx_q + 1'b1;
        rd_en      = 1'b0;
        rd_addr    = {rd_bank_q, rd_idx_q};
        case (rd_state_q)
            IDLE: begin
                if (bank_d[rd_bank_q] == FULL) begin
                    rd_state_d = PRIME;
                    rd_idx_d   = '0;
                end
            end
            PRIME: begin
                rd_en      = 1'b1;
                rd_state_d = STREAM;
            end
            STREAM: begin
                if (rd_done) begin
                    rd_bank_d  = ~rd_bank_q;
                    rd_idx_d   = '0;
                    rd_state_d = (bank_d[~rd_bank_q] == FULL) ? PRIME : IDLE;
                end else if (rd_fire) begin
                    rd_idx_d = rd_idx_nxt;
                    rd_en    = 1'b1;
                    rd_addr  = {rd_bank_q, rd_idx_nxt};
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (ovf_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            left_q       <= '0;
            have_left_q  <= 1'b0;
            mono_valid_q <= 1'b0;
            mono_data_q  <= '0;
            wr_state_q   <= FILL;
            wr_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_state_q   <= IDLE;
            rd_bank_q    <= 1'b0;
            rd_idx_q     <= '0;
            bank_q[0]    <= FREE;
            bank_q[1]    <= FREE;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            left_q       <= left_d;
            have_left_q  <= have_left_d;
            mono_valid_q <= mono_valid_d;
            mono_data_q  <= mono_data_d;
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_idx_q     <= rd_idx_d;
            bank_q       <= bank_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    audio_frame_ram #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ADDR_WIDTH   (IDX_W + 1)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_data (mono_data_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign frame_valid = (rd_state_q == STREAM);
    assign frame_data  = frame_valid ? ram_rd_data : '0;
    assign frame_last  = frame_valid && (rd_idx_q == LAST_IDX);
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule
